// File: rtl/fifo_ff_sync_p.sv
// Parametrised flip-flop synchronous FIFO: any DEPTH >= 2, FWFT or registered read,
// almost-empty/full levels, sticky error flags, flush. Optional stats: FIFO_FF_SYNC_P_STATS_EN.
module fifo_ff_sync_p #(
    parameter int WIDTH   = 32,
    parameter int DEPTH   = 16,
    parameter int REG_OUT = 0,
    parameter int AE_LVL  = 2,
    parameter int AF_LVL  = 14,
    parameter int OCW     = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             wr_en,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             rd_valid,
    output logic             empty,
    output logic             full,
    output logic             almost_empty,
    output logic             almost_full,
    output logic [OCW-1:0]   occup,
    output logic             overflow,
    output logic             underflow
`ifdef FIFO_FF_SYNC_P_STATS_EN
    ,
    output logic [OCW-1:0]   max_occup
`endif
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];

    logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [OCW-1:0] occup_q, occup_d;
    logic           empty_q, empty_d;
    logic           full_q, full_d;
    logic           ae_q, ae_d;
    logic           af_q, af_d;
    logic           overflow_q, overflow_d;
    logic           underflow_q, underflow_d;
    logic           wr_acc;
    logic           rd_acc;

    // Accepts use registered flags only; a flush suppresses both sides and the error flags.
    always_comb begin
        wr_acc      = wr_en & ~full_q & ~clr;
        rd_acc      = rd_en & ~empty_q & ~clr;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        occup_d     = occup_q;
        overflow_d  = overflow_q | (wr_en & full_q);
        underflow_d = underflow_q | (rd_en & empty_q);
        if (wr_acc) begin
            wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
        end
        if (rd_acc) begin
            rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
        end
        if (wr_acc && !rd_acc) begin
            occup_d = occup_q + 1'b1;
        end else if (rd_acc && !wr_acc) begin
            occup_d = occup_q - 1'b1;
        end
        if (clr) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            occup_d     = '0;
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end
        empty_d = (occup_d == '0);
        full_d  = (occup_d == OCW'(DEPTH));
        ae_d    = (occup_d <= OCW'(AE_LVL));
        af_d    = (occup_d >= OCW'(AF_LVL));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            occup_q     <= '0;
            empty_q     <= 1'b1;
            full_q      <= 1'b0;
            ae_q        <= 1'b1;
            af_q        <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            occup_q     <= occup_d;
            empty_q     <= empty_d;
            full_q      <= full_d;
            ae_q        <= ae_d;
            af_q        <= af_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage carries no reset so it can stay a plain register file.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_ptr_q] <= wr_data;
        end
    end

    generate
        if (REG_OUT != 0) begin : gen_reg_out
            logic [WIDTH-1:0] rd_data_q, rd_data_d;
            logic             rd_valid_q, rd_valid_d;

            always_comb begin
                rd_data_d  = rd_acc ? mem[rd_ptr_q] : rd_data_q;
                rd_valid_d = rd_acc;
            end

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    rd_data_q  <= '0;
                    rd_valid_q <= 1'b0;
                end else begin
                    rd_data_q  <= rd_data_d;
                    rd_valid_q <= rd_valid_d;
                end
            end

            assign rd_data  = rd_data_q;
            assign rd_valid = rd_valid_q;
        end else begin : gen_fwft
            assign rd_data  = empty_q ? '0 : mem[rd_ptr_q];
            assign rd_valid = ~empty_q;
        end
    endgenerate

`ifdef FIFO_FF_SYNC_P_STATS_EN
    logic [OCW-1:0] max_occup_q, max_occup_d;

    always_comb begin
        max_occup_d = (occup_d > max_occup_q) ? occup_d : max_occup_q;
        if (clr) begin
            max_occup_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            max_occup_q <= '0;
        end else begin
            max_occup_q <= max_occup_d;
        end
    end

    assign max_occup = max_occup_q;
`endif

    assign occup        = occup_q;
    assign empty        = empty_q;
    assign full         = full_q;
    assign almost_empty = ae_q;
    assign almost_full  = af_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

endmodule
